// File: rtl/uart_autobaud_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_autobaud_pkg : state encodings and 0x55 sync-frame constants
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_autobaud_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_IDLE  = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_MEASURE    = 3'd3,
        ST_STOP_CHK   = 3'd4,
        ST_CHECK      = 3'd5,
        ST_LOCKED     = 3'd6,
        ST_ERROR      = 3'd7
    } state_t;

    localparam logic [7:0] c_sync_char      = 8'h55;
    localparam int         c_edge_count     = 5;
    localparam int         c_interval_count = 4;

endpackage
`default_nettype wire

// File: rtl/uart_autobaud_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_autobaud_if : serial line, enable and divider-update signals
// Rev 1.0
// ---------------------------------------------------------------------------
interface uart_autobaud_if;
    logic        rx;
    logic        enable;
    logic        set_clock_div;
    logic [31:0] user_clock_div;
    logic        locked;
    logic        error;

    modport master (
        output rx, enable,
        input  set_clock_div, user_clock_div, locked, error
    );

    modport slave (
        input  rx, enable,
        output set_clock_div, user_clock_div, locked, error
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_edge_detect : 2-flop synchroniser and falling-edge detector
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_edge_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_rx,
    output logic      o_rx_sync,
    output logic      o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_rx;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_rx_sync = r_sync;
    assign o_fall    = r_sync_d & ~r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_autobaud.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_autobaud : measures 0x55 bit period and drives the UART clock divider
// Optional stop-bit check: UART_AUTOBAUD_STOP_CHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int COUNTER_WIDTH   = 24,
    parameter int IDLE_CYCLES     = 1024,
    parameter int TOLERANCE_SHIFT = 2,
    parameter int MIN_DIV         = 1,
    parameter int PRESCALER_COUNT = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_autobaud_if.slave  bus
);
    localparam int c_aw        = COUNTER_WIDTH + 2;
    localparam int c_iw        = $clog2(IDLE_CYCLES + 1);
    localparam int c_div_shift = 3 + $clog2(PRESCALER_COUNT);

    localparam logic [COUNTER_WIDTH-1:0] c_cnt_max       = '1;
    localparam logic [c_iw-1:0]          c_idle_last     = c_iw'(IDLE_CYCLES - 1);
    localparam logic [c_aw-1:0]          c_min_div       = c_aw'(MIN_DIV);
    localparam logic [1:0]               c_last_interval = 2'(c_edge_count - 2);

    logic w_rx_sync;
    logic w_fall;

    uart_rx_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .i_rx      (bus.rx),
        .o_rx_sync (w_rx_sync),
        .o_fall    (w_fall)
    );

    state_t                   r_state;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [c_iw-1:0]          r_idle_cnt;
    logic [1:0]               r_edge;
    logic [COUNTER_WIDTH-1:0] r_int [c_interval_count];
    logic                     r_set;
    logic [31:0]              r_div;
    logic                     r_locked;
    logic                     r_error;

    function automatic logic [c_aw-1:0] absdiff(input logic [c_aw-1:0] a, input logic [c_aw-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [c_aw-1:0] w_i1, w_i2, w_i3, w_i4;
    logic [c_aw-1:0] w_tol, w_total, w_div;
    logic            w_meas_ok;

    assign w_i1      = {2'b00, r_int[0]};
    assign w_i2      = {2'b00, r_int[1]};
    assign w_i3      = {2'b00, r_int[2]};
    assign w_i4      = {2'b00, r_int[3]};
    assign w_tol     = w_i1 >> TOLERANCE_SHIFT;
    assign w_total   = w_i1 + w_i2 + w_i3 + w_i4;
    // Total spans 8 bit periods; dividing by 8*PRESCALER_COUNT gives the UART divider.
    assign w_div     = w_total >> c_div_shift;
    assign w_meas_ok = (absdiff(w_i2, w_i1) <= w_tol) &&
                       (absdiff(w_i3, w_i1) <= w_tol) &&
                       (absdiff(w_i4, w_i1) <= w_tol) &&
                       (w_div >= c_min_div);

`ifdef UART_AUTOBAUD_STOP_CHECK_EN
    logic [c_aw-1:0] w_stop_wait;
    assign w_stop_wait = (w_i1 + (w_i1 << 1)) >> 2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idle_cnt <= '0;
            r_edge     <= '0;
            for (int i = 0; i < c_interval_count; i++) r_int[i] <= '0;
            r_set      <= 1'b0;
            r_div      <= '0;
            r_locked   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_set   <= 1'b0;
            r_error <= 1'b0;
            if (!bus.enable) begin
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_idle_cnt <= '0;
                        r_state    <= ST_WAIT_IDLE;
                    end
                    ST_WAIT_IDLE: begin
                        if (!w_rx_sync) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == c_idle_last) begin
                            r_idle_cnt <= '0;
                            r_state    <= ST_WAIT_START;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_START: begin
                        if (w_fall) begin
                            r_cnt   <= '0;
                            r_edge  <= '0;
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (r_cnt == c_cnt_max) begin
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end else if (w_fall) begin
                            // The counter started at 0 one cycle after the previous edge.
                            r_int[r_edge] <= r_cnt + 1'b1;
                            r_cnt         <= '0;
                            r_edge        <= r_edge + 1'b1;
                            if (r_edge == c_last_interval) begin
`ifdef UART_AUTOBAUD_STOP_CHECK_EN
                                r_state <= ST_STOP_CHK;
`else
                                r_state <= ST_CHECK;
`endif
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`ifdef UART_AUTOBAUD_STOP_CHECK_EN
                    ST_STOP_CHK: begin
                        if (r_cnt == c_cnt_max) begin
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end else if ({2'b00, r_cnt} == w_stop_wait) begin
                            if (w_rx_sync) begin
                                r_state <= ST_CHECK;
                            end else begin
                                r_error <= 1'b1;
                                r_state <= ST_ERROR;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                    ST_CHECK: begin
                        if (w_meas_ok) begin
                            r_set    <= 1'b1;
                            r_div    <= 32'(w_div);
                            r_locked <= 1'b1;
                            r_state  <= ST_LOCKED;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end
                    ST_LOCKED: r_state <= ST_LOCKED;
                    ST_ERROR: begin
                        r_idle_cnt <= '0;
                        r_state    <= ST_WAIT_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.set_clock_div  = r_set;
    assign bus.user_clock_div = r_div;
    assign bus.locked         = r_locked;
    assign bus.error          = r_error;
endmodule
`default_nettype wire

// File: doc/uart_autobaud.md
# uart_autobaud

Automatic baud-rate detector that pairs with the UART core's clock-divider port. It watches the serial receive line for the sync character 0x55 ('U') and measures the bit period in system clocks. It then drives `user_clock_div` and a one-cycle `set_clock_div` pulse into the UART, so the link locks to whatever rate the host transmits. It sits between the pad-level `rx` signal and the UART's `set_clock_div`/`user_clock_div` inputs.

## Interface
- `COUNTER_WIDTH`, 24: width of the edge-interval counter; a saturated counter means timeout.
- `IDLE_CYCLES`, 1024: consecutive synchronised-high cycles required before a start edge is accepted.
- `TOLERANCE_SHIFT`, 2: allowed interval deviation is `interval1 >> TOLERANCE_SHIFT` (25 %).
- `MIN_DIV`, 1: smallest legal `user_clock_div`; a smaller result is an error.
- `PRESCALER_COUNT`, 8: UART oversample ticks per bit; must be a power of two.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  raw serial line, asynchronous to `clk`.
- `enable`  in  1  level; high requests detection, low aborts and clears `locked`.
- `set_clock_div`  out  1  one-cycle pulse when a new divider is valid.
- `user_clock_div`  out  32  measured divider; holds its value between locks.
- `locked`  out  1  high from the `set_clock_div` pulse until `enable` falls.
- `error`  out  1  one-cycle pulse on any rejected measurement.

## Operation
- `rx` passes through a 2-flop synchroniser. A falling edge means the synchronised value is 1 then 0.
- States:
  - IDLE → WAIT_IDLE when `enable` is high.
  - WAIT_IDLE: the idle counter counts high cycles and resets on low. Go to WAIT_START at `IDLE_CYCLES`.
  - WAIT_START: on a falling edge, clear the interval counter, clear the edge index, and go to MEASURE.
  - MEASURE: the counter increments each cycle. On each falling edge, store the interval, restart the counter and increment the edge index. After the 4th interval, go to CHECK (or STOP_CHK if the macro is set).
  - CHECK: validate, then go to LOCKED or ERROR.
  - LOCKED holds while `enable` is high; `enable` low returns to IDLE.
  - ERROR pulses `error`, then returns to WAIT_IDLE.
- 0x55 framing: falling edges fall at bit times 0, 2, 4, 6 and 8. Each of the 4 intervals is nominally 2 bit periods, so the total is 8 bit periods.
- Validation: intervals 2–4 must each satisfy `|interval_i − interval1| ≤ interval1 >> TOLERANCE_SHIFT`. All arithmetic is unsigned, COUNTER_WIDTH+2 bits.
- Result: `total = sum of 4 intervals`; `div = total >> (3 + log2(PRESCALER_COUNT))`, which is `total >> 6` at the default. This matches the UART formula `CLOCK_RATE / (PRESCALER_COUNT * baud)`. A `div` below `MIN_DIV` is an error.
- Timeout: if the interval counter saturates at all-ones in MEASURE or STOP_CHK, the measurement is an error.
- `enable` low in any state: go to IDLE on the next cycle, clear `locked`, emit no pulse, and keep `user_clock_div` unchanged.
- A glitch edge during MEASURE counts as an edge; the tolerance check rejects it.

## Timing
- Reset values: state IDLE, `set_clock_div` 0, `user_clock_div` 0, `locked` 0, `error` 0, all counters 0.
- Edge detection lags pin transitions by 2 cycles. This is a constant offset, so intervals are unaffected.
- Fifth falling edge seen in cycle N → CHECK in cycle N+1 → in cycle N+2, `set_clock_div`=1, `user_clock_div` valid, and `locked`=1 (or `error`=1).
- `set_clock_div` is high for exactly one cycle per lock; `user_clock_div` is stable from that cycle onward.
- Relock requires `enable` to go low then high again.

## Configuration
- `UART_AUTOBAUD_STOP_CHECK_EN` defined:
  - After the 4th interval, enter STOP_CHK.
  - Wait `3 × interval1 / 4` cycles (1.5 bit periods past the fifth edge) and sample the synchronised `rx`.
  - A 1 proceeds to CHECK; a 0 goes to ERROR.
  - Latency grows by that wait plus 1 cycle.
- Undefined: STOP_CHK does not exist; MEASURE goes directly to CHECK.

## Structure
- Shared package: state encodings (IDLE, WAIT_IDLE, WAIT_START, MEASURE, STOP_CHK, CHECK, LOCKED, ERROR), the 0x55 sync constant, the edge count 5, and the interval count 4.
- Sub-module `uart_rx_edge_detect`: 2-flop synchroniser plus falling-edge detector. It outputs `rx_sync` and `fall`, and is reusable by the UART receive path.

## Test plan
- At 50 MHz, after 2000 idle cycles, send 0x55 with 868-cycle bits → `set_clock_div` pulses once, `user_clock_div`=108, `locked`=1.
- Send 0x55 with 434-cycle bits → `user_clock_div`=54. Drop `enable` → `locked`=0 next cycle; `user_clock_div` stays 54.
- Send 0x0D with 868-cycle bits → interval 2 is 2604 vs interval 1 of 1736, a deviation of 868 > 434 → `error` pulse, no `set_clock_div`, return to WAIT_IDLE.
- With `COUNTER_WIDTH`=12, send a start bit and then hold `rx` low → `error` when the counter reaches 4095.
- Lower `enable` mid-MEASURE after 2 edges → IDLE next cycle with no pulses. Re-enable and send a valid 0x55 → locks with `user_clock_div`=108.
- With `UART_AUTOBAUD_STOP_CHECK_EN` set, send 0x55 with the stop bit forced low → `error`. Send it with the stop bit high → `user_clock_div`=108.
